// File: rtl/rs_age_select.sv
// rs_age_select: unified reservation station with CAM wakeup
// and oldest-first select per FU class through an age matrix.
module rs_age_select #(
  parameter int DEPTH  = 16,
  parameter int DISP_W = 2,
  parameter int NUM_FU = 3,
  parameter int WAKE_W = 2,
  parameter int TAG_W  = 6,
  parameter int PAY_W  = 96,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1,
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int KW = (DISP_W > 1) ? $clog2(DISP_W) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [DISP_W-1:0]       disp_valid,
  output logic                    disp_ready,
  input  logic [DISP_W*FW-1:0]    disp_fu,
  input  logic [DISP_W*TAG_W-1:0] disp_src1_tag,
  input  logic [DISP_W-1:0]       disp_src1_rdy,
  input  logic [DISP_W*TAG_W-1:0] disp_src2_tag,
  input  logic [DISP_W-1:0]       disp_src2_rdy,
  input  logic [DISP_W*PAY_W-1:0] disp_payload,
  input  logic [WAKE_W-1:0]       wake_valid,
  input  logic [WAKE_W*TAG_W-1:0] wake_tag,
  output logic [NUM_FU-1:0]       iss_valid,
  input  logic [NUM_FU-1:0]       iss_ready,
  output logic [NUM_FU*TAG_W-1:0] iss_src1_tag,
  output logic [NUM_FU*TAG_W-1:0] iss_src2_tag,
  output logic [NUM_FU*PAY_W-1:0] iss_payload,
  output logic [CW-1:0]           free_count
);

  typedef struct packed {
    logic [FW-1:0]    fu;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_rdy;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_rdy;
    logic [PAY_W-1:0] pay;
  } ent_t;

  ent_t             ent_q  [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] old_q  [DEPTH];
  logic [DEPTH-1:0] old_d  [DEPTH];
  logic [CW-1:0]    free_q;

  logic [NUM_FU-1:0] iv_q;
  logic [TAG_W-1:0]  is1_q  [NUM_FU];
  logic [TAG_W-1:0]  is2_q  [NUM_FU];
  logic [PAY_W-1:0]  ipay_q [NUM_FU];

  ent_t              new_ent   [DISP_W];
  logic [IW-1:0]     alloc_idx [DISP_W];
  logic [DISP_W-1:0] disp_we;
  logic [DEPTH-1:0]  wr_en;
  logic [KW-1:0]     wr_k      [DEPTH];

  logic [DEPTH-1:0]  cand    [NUM_FU];
  logic [DEPTH-1:0]  pick    [NUM_FU];
  logic [IW-1:0]     sel_idx [NUM_FU];
  logic [NUM_FU-1:0] ld;
  logic [NUM_FU-1:0] fire;
  logic [DEPTH-1:0]  iss_clr;
  logic [CW-1:0]     n_acc;
  logic [CW-1:0]     n_iss;

  function automatic logic woke(
    input logic [TAG_W-1:0]        t,
    input logic [WAKE_W-1:0]       wv,
    input logic [WAKE_W*TAG_W-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_W; w++)
      if (wv[w] && wt[w*TAG_W +: TAG_W] == t) hit = 1'b1;
    return hit;
  endfunction

  assign disp_ready = free_q >= CW'(DISP_W);
  assign disp_we    = disp_valid & {DISP_W{disp_ready}};
  assign free_count = free_q;

  // Dispatching sources also see this cycle's broadcasts
  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      new_ent[k].fu     = disp_fu[k*FW +: FW];
      new_ent[k].s1_tag = disp_src1_tag[k*TAG_W +: TAG_W];
      new_ent[k].s2_tag = disp_src2_tag[k*TAG_W +: TAG_W];
      new_ent[k].s1_rdy = disp_src1_rdy[k] |
        woke(disp_src1_tag[k*TAG_W +: TAG_W], wake_valid, wake_tag);
      new_ent[k].s2_rdy = disp_src2_rdy[k] |
        woke(disp_src2_tag[k*TAG_W +: TAG_W], wake_valid, wake_tag);
      new_ent[k].pay    = disp_payload[k*PAY_W +: PAY_W];
    end
  end

  always_comb begin
    int cnt;
    cnt = 0;
    for (int k = 0; k < DISP_W; k++) alloc_idx[k] = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!vld_q[i]) begin
        for (int k = 0; k < DISP_W; k++)
          if (cnt == k) alloc_idx[k] = IW'(i);
        cnt++;
      end
  end

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++) wr_k[i] = '0;
    for (int k = 0; k < DISP_W; k++)
      if (disp_we[k]) begin
        wr_en[alloc_idx[k]] = 1'b1;
        wr_k[alloc_idx[k]]  = KW'(k);
      end
  end

  // Row i / col j: new entries are younger than all residents
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (wr_en[i] && wr_en[j])
          old_d[i][j] = wr_k[i] < wr_k[j];
        else if (wr_en[i])
          old_d[i][j] = 1'b0;
        else if (wr_en[j])
          old_d[i][j] = vld_q[i];
        else
          old_d[i][j] = old_q[i][j];
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      ld[f] = !iv_q[f] || iss_ready[f];
      for (int i = 0; i < DEPTH; i++)
        cand[f][i] = ld[f] && vld_q[i] &&
                     ent_q[i].s1_rdy && ent_q[i].s2_rdy &&
                     ent_q[i].fu == FW'(f);
    end
  end

  always_comb begin
    iss_clr = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        pick[f][i] = cand[f][i];
        for (int j = 0; j < DEPTH; j++)
          if (cand[f][j] && old_q[j][i]) pick[f][i] = 1'b0;
      end
      fire[f]    = |pick[f];
      sel_idx[f] = '0;
      for (int i = 0; i < DEPTH; i++)
        if (pick[f][i]) sel_idx[f] = IW'(i);
      iss_clr = iss_clr | pick[f];
    end
  end

  always_comb begin
    n_acc = '0;
    n_iss = '0;
    for (int k = 0; k < DISP_W; k++) n_acc = n_acc + CW'(disp_we[k]);
    for (int f = 0; f < NUM_FU; f++) n_iss = n_iss + CW'(fire[f]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      free_q <= CW'(DEPTH);
      iv_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        old_q[i] <= '0;
      end
      for (int f = 0; f < NUM_FU; f++) begin
        is1_q[f]  <= '0;
        is2_q[f]  <= '0;
        ipay_q[f] <= '0;
      end
    end else if (flush) begin
      vld_q  <= '0;
      free_q <= CW'(DEPTH);
      iv_q   <= '0;
    end else begin
      free_q <= free_q - n_acc + n_iss;
      for (int i = 0; i < DEPTH; i++) begin
        old_q[i] <= old_d[i];
        if (wr_en[i]) begin
          ent_q[i] <= new_ent[wr_k[i]];
          vld_q[i] <= 1'b1;
        end else begin
          if (iss_clr[i]) vld_q[i] <= 1'b0;
          if (vld_q[i] && woke(ent_q[i].s1_tag, wake_valid, wake_tag))
            ent_q[i].s1_rdy <= 1'b1;
          if (vld_q[i] && woke(ent_q[i].s2_tag, wake_valid, wake_tag))
            ent_q[i].s2_rdy <= 1'b1;
        end
      end
      for (int f = 0; f < NUM_FU; f++)
        if (ld[f]) begin
          iv_q[f] <= fire[f];
          if (fire[f]) begin
            is1_q[f]  <= ent_q[sel_idx[f]].s1_tag;
            is2_q[f]  <= ent_q[sel_idx[f]].s2_tag;
            ipay_q[f] <= ent_q[sel_idx[f]].pay;
          end
        end
    end
  end

  always_comb begin
    iss_valid = iv_q;
    for (int f = 0; f < NUM_FU; f++) begin
      iss_src1_tag[f*TAG_W +: TAG_W] = is1_q[f];
      iss_src2_tag[f*TAG_W +: TAG_W] = is2_q[f];
      iss_payload[f*PAY_W +: PAY_W]  = ipay_q[f];
    end
  end

  a_free_range: assert property (@(posedge clk) disable iff (!reset)
    free_q <= CW'(DEPTH));

  a_single_fu: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(iss_clr & ~vld_q) && (n_iss <= CW'(NUM_FU)));

  for (genvar k = 0; k < DISP_W; k++) begin : g_fu_chk
    a_fu_known: assert property (@(posedge clk) disable iff (!reset)
      disp_we[k] |->
        ({1'b0, disp_fu[k*FW +: FW]} < (FW+1)'(NUM_FU)));
  end

endmodule

// File: tb/tb_rs_age_select.sv
// Directed bench for rs_age_select: latency, wakeup, bypass,
// backpressure, full, flush and async reset.
module tb_rs_age_select;
  logic         clk;
  logic         reset;
  logic         flush;
  logic [1:0]   disp_valid;
  logic         disp_ready;
  logic [3:0]   disp_fu;
  logic [11:0]  disp_src1_tag;
  logic [1:0]   disp_src1_rdy;
  logic [11:0]  disp_src2_tag;
  logic [1:0]   disp_src2_rdy;
  logic [191:0] disp_payload;
  logic [1:0]   wake_valid;
  logic [11:0]  wake_tag;
  logic [2:0]   iss_valid;
  logic [2:0]   iss_ready;
  logic [17:0]  iss_src1_tag;
  logic [17:0]  iss_src2_tag;
  logic [287:0] iss_payload;
  logic [4:0]   free_count;

  int n_chk = 0;
  int n_err = 0;

  rs_age_select dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_fu(disp_fu),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
    .disp_payload(disp_payload),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag),
    .iss_payload(iss_payload), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = '0;
    wake_valid = '0;
    flush      = 1'b0;
  endtask

  task automatic slot(input int k, input logic [1:0] fu,
                      input logic [5:0] t1, input logic r1,
                      input logic [5:0] t2, input logic r2,
                      input logic [95:0] pay);
    disp_valid[k]          = 1'b1;
    disp_fu[k*2 +: 2]      = fu;
    disp_src1_tag[k*6 +: 6] = t1;
    disp_src1_rdy[k]       = r1;
    disp_src2_tag[k*6 +: 6] = t2;
    disp_src2_rdy[k]       = r2;
    disp_payload[k*96 +: 96] = pay;
  endtask

  task automatic wake(input int p, input logic [5:0] t);
    wake_valid[p]      = 1'b1;
    wake_tag[p*6 +: 6] = t;
  endtask

  function automatic logic [95:0] pay_of(input int f);
    return iss_payload[f*96 +: 96];
  endfunction

  function automatic logic [5:0] t1_of(input int f);
    return iss_src1_tag[f*6 +: 6];
  endfunction

  function automatic logic [5:0] t2_of(input int f);
    return iss_src2_tag[f*6 +: 6];
  endfunction

  initial begin
    reset = 1'b0;
    idle();
    iss_ready     = 3'b111;
    disp_fu       = '0;
    disp_src1_tag = '0;
    disp_src1_rdy = '0;
    disp_src2_tag = '0;
    disp_src2_rdy = '0;
    disp_payload  = '0;
    wake_tag      = '0;
    #12;
    check("rst_iss_valid", iss_valid, 0);
    check("rst_free", free_count, 16);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_payload", iss_payload[127:0], 0);
    @(negedge clk);
    reset = 1'b1;

    // two ready ALU ops, older issues first
    slot(0, 0, 5, 1, 0, 1, 96'hA0);
    slot(1, 0, 6, 1, 0, 1, 96'hA1);
    tick();
    idle();
    check("t1_free14", free_count, 14);
    check("t1_novalid", iss_valid, 0);
    tick();
    check("t1_v0", iss_valid, 3'b001);
    check("t1_pay0", pay_of(0), 96'hA0);
    check("t1_tag0", t1_of(0), 5);
    check("t1_free15", free_count, 15);
    tick();
    check("t1_v1", iss_valid, 3'b001);
    check("t1_pay1", pay_of(0), 96'hA1);
    check("t1_tag1", t1_of(0), 6);
    check("t1_free16", free_count, 16);
    tick();
    check("t1_drain", iss_valid, 0);

    // wakeup latency
    slot(0, 1, 9, 0, 0, 1, 96'hB0);
    tick();
    idle();
    check("t2_wait0", iss_valid, 0);
    tick();
    check("t2_wait1", iss_valid, 0);
    wake(0, 9);
    tick();
    idle();
    check("t2_not_early", iss_valid, 0);
    tick();
    check("t2_issue", iss_valid, 3'b010);
    check("t2_pay", pay_of(1), 96'hB0);
    check("t2_tag", t1_of(1), 9);
    tick();
    check("t2_drain", iss_valid, 0);

    // same-cycle bypass on a sparse slot
    slot(1, 0, 3, 1, 12, 0, 96'hC1);
    wake(1, 12);
    tick();
    idle();
    check("t3_free15", free_count, 15);
    tick();
    check("t3_issue", iss_valid, 3'b001);
    check("t3_pay", pay_of(0), 96'hC1);
    check("t3_tag2", t2_of(0), 12);
    tick();
    check("t3_drain", iss_valid, 0);

    // backpressure on mem channel
    iss_ready = 3'b011;
    slot(0, 2, 1, 1, 2, 1, 96'hD0);
    slot(1, 2, 1, 1, 2, 1, 96'hD1);
    tick();
    idle();
    slot(0, 2, 1, 1, 2, 1, 96'hD2);
    tick();
    idle();
    check("t4_load", iss_valid, 3'b100);
    check("t4_pay0", pay_of(2), 96'hD0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t4_hold_v", iss_valid, 3'b100);
      check("t4_hold_pay", pay_of(2), 96'hD0);
    end
    check("t4_hold_free", free_count, 14);
    iss_ready = 3'b111;
    tick();
    check("t4_pay1", pay_of(2), 96'hD1);
    check("t4_v1", iss_valid, 3'b100);
    tick();
    check("t4_pay2", pay_of(2), 96'hD2);
    tick();
    check("t4_drain", iss_valid, 0);
    check("t4_free16", free_count, 16);

    // fill to 15 entries
    for (int c = 0; c < 7; c++) begin
      slot(0, 0, 40, 0, 0, 1, 96'h100 + 96'(c));
      slot(1, 0, 40, 0, 0, 1, 96'h200 + 96'(c));
      tick();
      idle();
    end
    check("t5_free2", free_count, 2);
    check("t5_rdy2", disp_ready, 1);
    slot(0, 0, 41, 0, 0, 1, 96'hF15);
    tick();
    idle();
    check("t5_free1", free_count, 1);
    check("t5_full", disp_ready, 0);
    slot(0, 1, 0, 1, 0, 1, 96'hBAD0);
    slot(1, 1, 0, 1, 0, 1, 96'hBAD1);
    tick();
    idle();
    check("t5_ignored_free", free_count, 1);
    check("t5_ignored_iss", iss_valid, 0);
    wake(0, 41);
    tick();
    idle();
    check("t5_wake_wait", iss_valid, 0);
    tick();
    check("t5_issue", iss_valid, 3'b001);
    check("t5_pay", pay_of(0), 96'hF15);
    check("t5_free_back", free_count, 2);
    check("t5_rdy_back", disp_ready, 1);

    // flush to clean state
    flush = 1'b1;
    tick();
    idle();
    check("t6_flush_v", iss_valid, 0);
    check("t6_flush_free", free_count, 16);
    tick();
    check("t6_flush_gone", iss_valid, 0);

    // fill issue regs, then flush with concurrent dispatch
    iss_ready = 3'b000;
    slot(0, 0, 1, 1, 1, 1, 96'hE0);
    slot(1, 1, 1, 1, 1, 1, 96'hE1);
    tick();
    slot(0, 2, 1, 1, 1, 1, 96'hE2);
    slot(1, 0, 1, 1, 1, 1, 96'hE3);
    tick();
    slot(0, 1, 1, 1, 1, 1, 96'hE4);
    slot(1, 2, 1, 1, 1, 1, 96'hE5);
    tick();
    slot(0, 0, 1, 1, 1, 1, 96'hE6);
    slot(1, 1, 1, 1, 1, 1, 96'hE7);
    tick();
    idle();
    check("t6_pre_v", iss_valid, 3'b111);
    check("t6_pre_free", free_count, 11);
    check("t6_pre_pay", pay_of(2), 96'hE2);
    flush = 1'b1;
    slot(0, 0, 1, 1, 1, 1, 96'hEE);
    tick();
    idle();
    check("t6_v", iss_valid, 0);
    check("t6_free", free_count, 16);
    iss_ready = 3'b111;
    tick();
    check("t6_empty", iss_valid, 0);
    check("t6_free_stay", free_count, 16);

    // async reset mid-operation
    iss_ready = 3'b000;
    slot(0, 0, 1, 1, 1, 1, 96'hF0);
    slot(1, 1, 1, 1, 1, 1, 96'hF1);
    tick();
    slot(0, 0, 1, 1, 1, 1, 96'hF2);
    slot(1, 1, 1, 1, 1, 1, 96'hF3);
    tick();
    idle();
    check("t7_pre_v", iss_valid, 3'b011);
    check("t7_pre_free", free_count, 14);
    #3;
    reset = 1'b0;
    #1;
    check("t7_v", iss_valid, 0);
    check("t7_free", free_count, 16);
    check("t7_rdy", disp_ready, 1);
    check("t7_pay", pay_of(0), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
